// File: rtl/jk_pkg.sv
// Shared JK-cell definitions: mode encodings and the characteristic equation.
package jk_pkg;

    // {J,K} drive patterns for a JK cell
    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_mode_e;

    // Next Q of a JK cell given current Q and J/K inputs
    function automatic logic jk_next(input logic q, input logic j, input logic k);
        case ({j, k})
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK storage cell with synchronous active-high reset.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic q_bar
);

    logic r_q;

    // Q register: reset clears, otherwise follow the JK characteristic equation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else begin
            r_q <= jk_next(r_q, j, k);
        end
    end

    assign q     = r_q;
    assign q_bar = ~r_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-(MAX+1) up/down counter: a steering stage computes per-bit JK modes
// from the current Q outputs, and a bank of JK cells holds the count.
module jk_updown_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] count_bar,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic [WIDTH-1:0] w_load_v;
    logic             w_oor;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_chain;
    jk_mode_e         w_mode [WIDTH];
    logic             r_wrap;

    // Out-of-range and load clamping only exist when MAX leaves codes unused
    if (MAX < (2 ** WIDTH) - 1) begin : g_partial
        assign w_oor    = (count > MAX_V);
        assign w_load_v = (load_val > MAX_V) ? MAX_V : load_val;
    end else begin : g_full
        assign w_oor    = 1'b0;
        assign w_load_v = load_val;
    end

    assign w_at_max  = (count == MAX_V);
    assign w_at_zero = (count == '0);

    // Steering: pick a JK mode per bit (load > wrap/out-of-range > ripple count)
    always_comb begin
        w_j     = '0;
        w_k     = '0;
        w_chain = 1'b1;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_mode[i] = JK_HOLD;
        end
        if (load) begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                w_mode[i] = w_load_v[i] ? JK_SET : JK_RESET;
            end
        end else if (en) begin
            if (w_oor || (up && w_at_max)) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_mode[i] = JK_RESET;
                end
            end else if (!up && w_at_zero) begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    w_mode[i] = MAX_V[i] ? JK_SET : JK_RESET;
                end
            end else begin
                // w_chain tracks "all lower bits are ones" (up) or "all zeros" (down)
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (w_chain) begin
                        w_mode[i] = JK_TOGGLE;
                    end
                    w_chain = w_chain & (up ? count[i] : ~count[i]);
                end
            end
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            {w_j[i], w_k[i]} = w_mode[i];
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .j     (w_j[g]),
            .k     (w_k[g]),
            .q     (count[g]),
            .q_bar (count_bar[g])
        );
    end

    assign tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

    // Wrap pulse: terminal count delayed by one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= tc;
        end
    end

    assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_updown_counter.sv
// Self-checking bench: two counters (MAX=15 and MAX=9) share stimulus and are
// compared every cycle against an arithmetic model, plus literal spot checks.
module tb_jk_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] c15, cb15, c9, cb9;
    logic       tc15, w15, tc9, w9;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(4), .MAX(15)) dut15 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c15), .count_bar(cb15), .tc(tc15), .wrap(w15)
    );

    jk_updown_counter #(.WIDTH(4), .MAX(9)) dut9 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(c9), .count_bar(cb9), .tc(tc9), .wrap(w9)
    );

    // Reference model: plain modular arithmetic per counter
    int mc [2];
    bit mw [2];
    bit mvalid = 1'b0;
    int mmax [2] = '{15, 9};

    function automatic bit mtc(input int c, input int m);
        return en && !load && (up ? (c == m) : (c == 0));
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            bit t;
            t = mtc(mc[d], mmax[d]);
            if (rst) begin
                mc[d] = 0;
                mw[d] = 1'b0;
            end else begin
                mw[d] = t;
                if (load)
                    mc[d] = (int'(load_val) > mmax[d]) ? mmax[d] : int'(load_val);
                else if (en) begin
                    if (up) mc[d] = (mc[d] == mmax[d]) ? 0 : mc[d] + 1;
                    else    mc[d] = (mc[d] == 0) ? mmax[d] : mc[d] - 1;
                end
            end
        end
        if (rst) mvalid = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (mvalid) begin
            chk("count15", int'(c15), mc[0]);
            chk("cbar15", int'(cb15), 15 - mc[0]);
            chk("tc15", int'(tc15), int'(mtc(mc[0], 15)));
            chk("wrap15", int'(w15), int'(mw[0]));
            chk("count9", int'(c9), mc[1]);
            chk("cbar9", int'(cb9), 15 - mc[1]);
            chk("tc9", int'(tc9), int'(mtc(mc[1], 9)));
            chk("wrap9", int'(w9), int'(mw[1]));
        end
    end

    // Inputs change 2 time units after a rising edge and apply at the next one
    task automatic step(input bit r, input bit l, input int lv, input bit e, input bit u);
        @(posedge clk);
        #2;
        rst      = r;
        load     = l;
        load_val = 4'(lv);
        en       = e;
        up       = u;
    endtask

    initial begin
        // Reset
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_count", int'(c15), 0);
        chk("rst_cbar", int'(cb15), 15);
        chk("rst_wrap", int'(w15), 0);
        chk("rst_tc", int'(tc15), 0);

        // Up count through wrap
        for (int i = 0; i < 16; i++) step(0, 0, 0, 1, 1);
        @(negedge clk);
        chk("up_at15", int'(c15), 15);
        chk("up_tc15", int'(tc15), 1);
        chk("up_wrap_lo", int'(w15), 0);
        step(0, 0, 0, 1, 1);
        @(negedge clk);
        chk("up_wrapped", int'(c15), 0);
        chk("up_wrap_pulse", int'(w15), 1);

        // Modulo-10 down count
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("dn_zero", int'(c9), 0);
        chk("dn_tc9", int'(tc9), 1);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("dn_wrap9", int'(c9), 9);
        chk("dn_cbar9", int'(cb9), 6);
        chk("dn_wrap_pulse9", int'(w9), 1);
        chk("dn_wrap15", int'(c15), 15);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("dn_again9", int'(c9), 9);

        // Load beats count; clamping against MAX
        step(0, 1, 6, 1, 1);
        @(negedge clk);
        chk("ld_tc9", int'(tc9), 0);
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("ld6_15", int'(c15), 6);
        chk("ld6_9", int'(c9), 6);
        step(0, 1, 13, 1, 1);
        @(negedge clk);
        chk("ld13_tc9", int'(tc9), 0);
        step(0, 0, 0, 0, 1);
        @(negedge clk);
        chk("ld13_clamp9", int'(c9), 9);
        chk("ld13_15", int'(c15), 13);

        // Hold and direction change
        step(0, 1, 5, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("hold5", int'(c15), 5);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("dir_up6", int'(c15), 6);
        step(0, 0, 0, 1, 1);
        @(negedge clk);
        chk("dir_dn5", int'(c9), 5);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("dir_up6b", int'(c15), 6);

        // Reset wins over load and enable
        step(0, 1, 11, 0, 0);
        step(1, 1, 3, 1, 1);
        @(negedge clk);
        chk("mid_11", int'(c15), 11);
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst", int'(c15), 0);
        chk("mid_wrap", int'(w15), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                 int'($urandom_range(15)), ($urandom_range(3) != 0),
                 1'($urandom_range(1)));
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
